// File: rtl/ycbcr422_unpacker_if.sv
// ycbcr422_unpacker_if: packed 4:2:2 byte stream in, per-pixel YCbCr triple plus side-band out
interface ycbcr422_unpacker_if #(parameter int DSIZE = 8, parameter int XSIZE = 11);
  logic in_valid;
  logic in_sol;
  logic [DSIZE-1:0] in_data;
  logic [DSIZE-1:0] outY;
  logic [DSIZE-1:0] outCb;
  logic [DSIZE-1:0] outCr;
  logic out_valid;
  logic out_sol;
  logic [XSIZE-1:0] out_x;
  logic sync_err;
  modport master (output in_valid, in_sol, in_data,
                  input outY, outCb, outCr, out_valid, out_sol, out_x, sync_err);
  modport slave (input in_valid, in_sol, in_data,
                 output outY, outCb, outCr, out_valid, out_sol, out_x, sync_err);
endinterface

// File: rtl/ycbcr422_unpacker.sv
// ycbcr422_unpacker: Cb Y0 Cr Y1 byte stream to one Y/Cb/Cr triple per pixel, 1-clock latency.
// Define YCBCR_CLAMP_EN to clamp emitted components to the legal video range.
module ycbcr422_unpacker #(
  parameter int DSIZE = 8,
  parameter int XSIZE = 11
) (
  input logic clock,
  input logic reset_n,
  ycbcr422_unpacker_if.slave bus
);
  localparam logic [1:0] P_CB = 2'd0;
  localparam logic [1:0] P_Y0 = 2'd1;
  localparam logic [1:0] P_CR = 2'd2;
  localparam logic [1:0] P_Y1 = 2'd3;
  logic [1:0] phase;
  logic [DSIZE-1:0] cb_hold, y0_hold, cr_hold;
  logic [DSIZE-1:0] y_sel, cr_sel, y_c, cb_c, cr_c;
  logic [XSIZE-1:0] x_next;
  logic sol_pend;
  logic take, resync, emit;
  assign take = bus.in_valid;
  assign resync = take & bus.in_sol;
  // a resync byte is always Cb, so it never emits even on an emitting phase
  assign emit = take & ~bus.in_sol & (phase == P_CR || phase == P_Y1);
  assign y_sel = phase == P_CR ? y0_hold : bus.in_data;
  assign cr_sel = phase == P_CR ? bus.in_data : cr_hold;
`ifdef YCBCR_CLAMP_EN
  localparam logic [DSIZE-1:0] LO = DSIZE'(16 << (DSIZE - 8));
  localparam logic [DSIZE-1:0] Y_HI = DSIZE'(235 << (DSIZE - 8));
  localparam logic [DSIZE-1:0] C_HI = DSIZE'(240 << (DSIZE - 8));
  function automatic logic [DSIZE-1:0] clip(input logic [DSIZE-1:0] v, input logic [DSIZE-1:0] hi);
    return v < LO ? LO : v > hi ? hi : v;
  endfunction
  assign y_c = clip(y_sel, Y_HI);
  assign cb_c = clip(cb_hold, C_HI);
  assign cr_c = clip(cr_sel, C_HI);
`else
  assign y_c = y_sel;
  assign cb_c = cb_hold;
  assign cr_c = cr_sel;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= P_CB;
      cb_hold <= '0;
      y0_hold <= '0;
      cr_hold <= '0;
      x_next <= '0;
      sol_pend <= 1'b0;
      bus.outY <= '0;
      bus.outCb <= '0;
      bus.outCr <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sol <= 1'b0;
      bus.out_x <= '0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.out_valid <= emit;
      bus.out_sol <= emit & sol_pend;
      bus.sync_err <= resync & (phase != P_CB);
      if (take) phase <= resync ? P_Y0 : phase + 2'd1;
      if (take & (bus.in_sol | phase == P_CB)) cb_hold <= bus.in_data;
      if (take & ~bus.in_sol & phase == P_Y0) y0_hold <= bus.in_data;
      if (take & ~bus.in_sol & phase == P_CR) cr_hold <= bus.in_data;
      if (resync) begin
        x_next <= '0;
        sol_pend <= 1'b1;
      end else if (emit) begin
        x_next <= x_next + 1'b1;
        sol_pend <= 1'b0;
      end
      if (emit) begin
        bus.outY <= y_c;
        bus.outCb <= cb_c;
        bus.outCr <= cr_c;
        bus.out_x <= x_next;
      end
    end
  end
endmodule

// File: tb/tb_ycbcr422_unpacker.sv
// tb_ycbcr422_unpacker: directed and random byte streams checked against a byte-list reference model
module tb_ycbcr422_unpacker;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  ycbcr422_unpacker_if #(.DSIZE(8), .XSIZE(11)) bus();
  ycbcr422_unpacker #(.DSIZE(8), .XSIZE(11)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  logic [7:0] grp [4];
  int n = 0;
  int col = 0;
  logic solp = 1'b0;
  logic [7:0] my = 0, mcb = 0, mcr = 0;
  function automatic logic [7:0] lim(input logic [7:0] v, input logic [7:0] hi);
`ifdef YCBCR_CLAMP_EN
    return v < 16 ? 8'd16 : v > hi ? hi : v;
`else
    return hi == 0 ? v : v;
`endif
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    n = 0; col = 0; solp = 1'b0; my = 0; mcb = 0; mcr = 0;
  endtask
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    logic ev = 1'b0, ee = 1'b0, es = 1'b0;
    int ex = 0;
    bus.in_valid = v; bus.in_sol = s; bus.in_data = d;
    if (v) begin
      if (s) begin
        ee = n != 0;
        grp[0] = d; n = 1; col = 0; solp = 1'b1;
      end else begin
        grp[n] = d;
        n++;
        if (n >= 3) begin
          ev = 1'b1;
          my = lim(n == 3 ? grp[1] : d, 8'd235);
          mcb = lim(grp[0], 8'd240);
          mcr = lim(grp[2], 8'd240);
          es = solp; ex = col;
          col = (col + 1) % 2048; solp = 1'b0;
          if (n == 4) n = 0;
        end
      end
    end
    @(posedge clock); #1;
    check("valid", 32'(bus.out_valid), 32'(ev));
    check("err", 32'(bus.sync_err), 32'(ee));
    check("y", 32'(bus.outY), 32'(my));
    check("cb", 32'(bus.outCb), 32'(mcb));
    check("cr", 32'(bus.outCr), 32'(mcr));
    if (ev) begin
      check("sol", 32'(bus.out_sol), 32'(es));
      check("x", 32'(bus.out_x), 32'(ex));
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_y"}, 32'(bus.outY), 0);
    check({tag, "_cb"}, 32'(bus.outCb), 0);
    check({tag, "_cr"}, 32'(bus.outCr), 0);
    check({tag, "_v"}, 32'(bus.out_valid), 0);
    check({tag, "_sol"}, 32'(bus.out_sol), 0);
    check({tag, "_x"}, 32'(bus.out_x), 0);
    check({tag, "_err"}, 32'(bus.sync_err), 0);
  endtask
  initial begin
    logic [7:0] grpa [4];
    logic [7:0] clampv [4];
    grpa[0] = 8'h80; grpa[1] = 8'h10; grpa[2] = 8'h90; grpa[3] = 8'h20;
    clampv[0] = 8'h00; clampv[1] = 8'h05; clampv[2] = 8'hFF; clampv[3] = 8'hF0;
    bus.in_valid = 1'b0; bus.in_sol = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clock);
    #1 check_zero("rst");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, grpa[i]);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, grpa[i]);
      for (int k = 0; k < 3; k++) step(1'b0, k == 1, 8'hAA);
    end
    step(1'b1, 1'b0, 8'h80);
    step(1'b1, 1'b0, 8'h10);
    step(1'b1, 1'b1, 8'h70);
    step(1'b1, 1'b0, 8'h30);
    step(1'b1, 1'b0, 8'h60);
    step(1'b1, 1'b0, 8'h40);
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b0, 8'h44);
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b1, 8'h66);
    for (int i = 0; i < 4100; i++) step(1'b1, i == 0, 8'($urandom_range(0, 255)));
    step(1'b1, 1'b1, 8'h80);
    step(1'b1, 1'b0, 8'h10);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1 check_zero("amid");
    model_reset();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, grpa[i]);
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, clampv[i]);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      logic v = $urandom_range(0, 9) < 7;
      step(v, $urandom_range(0, 39) == 0, 8'($urandom_range(0, 255)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
